// File: rtl/rehman_seq_mul8_ctrl.sv
// Sequential 8x8 unsigned multiplier controller.
// One 4x4 core is reused across the four nibble cross-products of an 8x8
// operation. Steps whose nibble pair contains a zero nibble can be skipped.
//
// state | meaning
// IDLE  | ready for operands, accumulator idle
// CALC  | executing one pending nibble step per cycle
// DONE  | result presented on y, waiting for the sink
module rehman_seq_mul8_ctrl #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        approx_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT       state;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic        approxSel;
  logic [15:0] acc;
  logic [3:0]  stepMask;

  logic [3:0]  maskIn;
  logic [1:0]  stepIdx;
  logic [3:0]  nibA;
  logic [3:0]  nibB;
  logic [7:0]  stepProd;
  logic [15:0] stepShifted;
  logic [15:0] accNext;
  logic [3:0]  maskNext;

  // 2x2 approximate cell: the a0&b0 term is deliberately dropped and the
  // carry is folded into bits 0 and 3.
  function automatic logic [3:0] approxCell(input logic [1:0] x, input logic [1:0] w);
    logic p01, p10, q;
    p01 = x[0] & w[1];
    p10 = x[1] & w[0];
    q   = x[1] & w[1];
    return {p01 & p10, (p01 & p10) ^ q, p01 ^ p10, p01 & p10};
  endfunction

  // 4x4 approximate core built from four 2x2 cells; the sum never exceeds 225.
  function automatic logic [7:0] approxCore(input logic [3:0] x, input logic [3:0] w);
    logic [7:0] ll, hl, lh, hh;
    ll = {4'd0, approxCell(x[1:0], w[1:0])};
    hl = {4'd0, approxCell(x[3:2], w[1:0])};
    lh = {4'd0, approxCell(x[1:0], w[3:2])};
    hh = {4'd0, approxCell(x[3:2], w[3:2])};
    return ll + (hl << 2) + (lh << 2) + (hh << 4);
  endfunction

  // Step mask built from the incoming operands at the accepting edge.
  always_comb begin
    maskIn = 4'b1111;
    if (ZERO_SKIP) begin
      maskIn[0] = (|a[3:0]) & (|b[3:0]);
      maskIn[1] = (|a[7:4]) & (|b[3:0]);
      maskIn[2] = (|a[3:0]) & (|b[7:4]);
      maskIn[3] = (|a[7:4]) & (|b[7:4]);
    end
  end

  // Lowest pending step: bit 0 of the index picks the a nibble, bit 1 the b nibble.
  always_comb begin
    stepIdx = 2'd0;
    if (stepMask[0])      stepIdx = 2'd0;
    else if (stepMask[1]) stepIdx = 2'd1;
    else if (stepMask[2]) stepIdx = 2'd2;
    else if (stepMask[3]) stepIdx = 2'd3;
  end

  // Shared core, step shift and accumulate.
  always_comb begin
    nibA     = stepIdx[0] ? opA[7:4] : opA[3:0];
    nibB     = stepIdx[1] ? opB[7:4] : opB[3:0];
    stepProd = approxSel ? approxCore(nibA, nibB) : ({4'd0, nibA} * {4'd0, nibB});
    case (stepIdx)
      2'd0:    stepShifted = {8'd0, stepProd};
      2'd3:    stepShifted = {stepProd, 8'd0};
      default: stepShifted = {4'd0, stepProd, 4'd0};
    endcase
    accNext  = acc + stepShifted;
    maskNext = stepMask & ~(4'b0001 << stepIdx);
  end

  // Controller FSM with registered handshake outputs and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opA       <= 8'd0;
      opB       <= 8'd0;
      approxSel <= 1'b0;
      acc       <= 16'd0;
      stepMask  <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= 16'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opA       <= a;
            opB       <= b;
            approxSel <= approx_en;
            acc       <= 16'd0;
            stepMask  <= maskIn;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            if (maskIn != 4'd0) begin
              state <= CALC;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              y         <= 16'd0;
            end
          end
        end
        CALC: begin
          acc      <= accNext;
          stepMask <= maskNext;
          if (maskNext == 4'd0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            y         <= accNext;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rehman_seq_mul8_ctrl.sv
// Bench for rehman_seq_mul8_ctrl: instance 0 skips zero nibbles, instance 1
// always runs all four steps. A transaction-level model predicts the outputs
// of both instances every cycle; directed transactions pin literal results.
module tb_rehman_seq_mul8_ctrl;

  logic        clk;
  logic        rstN;
  logic [1:0]  inValid;
  logic [1:0]  outReady;
  logic [1:0]  aeIn;
  logic [7:0]  aIn [2];
  logic [7:0]  bIn [2];
  logic [1:0]  inReadyW;
  logic [1:0]  outValidW;
  logic [1:0]  busyW;
  logic [15:0] yW [2];

  int checks = 0;
  int errors = 0;

  int          mPhase [2] = '{0, 0};
  int          mLeft  [2] = '{0, 0};
  logic [15:0] mPend  [2] = '{16'd0, 16'd0};
  logic [15:0] mY     [2] = '{16'd0, 16'd0};

  rehman_seq_mul8_ctrl #(.ZERO_SKIP(1'b1)) dut0 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[0]), .in_ready(inReadyW[0]),
    .a(aIn[0]), .b(bIn[0]), .approx_en(aeIn[0]), .out_valid(outValidW[0]),
    .out_ready(outReady[0]), .y(yW[0]), .busy(busyW[0])
  );

  rehman_seq_mul8_ctrl #(.ZERO_SKIP(1'b0)) dut1 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[1]), .in_ready(inReadyW[1]),
    .a(aIn[1]), .b(bIn[1]), .approx_en(aeIn[1]), .out_valid(outValidW[1]),
    .out_ready(outReady[1]), .y(yW[1]), .busy(busyW[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference arithmetic straight from the cell equations.
  function automatic int modelCell(input int x, input int w);
    int a0, a1, b0, b1, p01, p10, q;
    a0 = x & 1; a1 = (x >> 1) & 1; b0 = w & 1; b1 = (w >> 1) & 1;
    p01 = a0 & b1; p10 = a1 & b0; q = a1 & b1;
    return (p01 & p10) + 2 * (p01 ^ p10) + 4 * ((p01 & p10) ^ q) + 8 * (p01 & p10);
  endfunction

  function automatic int modelCore(input int x, input int w);
    return modelCell(x % 4, w % 4) + 4 * modelCell(x / 4, w % 4)
         + 4 * modelCell(x % 4, w / 4) + 16 * modelCell(x / 4, w / 4);
  endfunction

  function automatic int nibbleOf(input int v, input bit hi);
    return hi ? (v / 16) : (v % 16);
  endfunction

  function automatic bit stepRuns(input int av, input int bv, input int s, input bit zs);
    if (!zs) return 1'b1;
    return (nibbleOf(av, s % 2 == 1) != 0) && (nibbleOf(bv, s >= 2) != 0);
  endfunction

  function automatic logic [15:0] modelResult(input int av, input int bv, input bit ae, input bit zs);
    int sum, an, bn;
    int scale [4] = '{1, 16, 16, 256};
    sum = 0;
    for (int s = 0; s < 4; s++) begin
      an = nibbleOf(av, s % 2 == 1);
      bn = nibbleOf(bv, s >= 2);
      if (stepRuns(av, bv, s, zs))
        sum += (ae ? modelCore(an, bn) : an * bn) * scale[s];
    end
    return sum[15:0];
  endfunction

  function automatic int modelSteps(input int av, input int bv, input bit zs);
    int n;
    n = 0;
    for (int s = 0; s < 4; s++) if (stepRuns(av, bv, s, zs)) n++;
    return n;
  endfunction

  // Transaction-level model: idle / computing for k cycles / holding result.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 2; i++) begin
        mPhase[i] <= 0;
        mLeft[i]  <= 0;
        mY[i]     <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (mPhase[i])
          0: if (inValid[i]) begin
               mPend[i] <= modelResult(int'(aIn[i]), int'(bIn[i]), aeIn[i], i == 0);
               mLeft[i] <= modelSteps(int'(aIn[i]), int'(bIn[i]), i == 0);
               if (modelSteps(int'(aIn[i]), int'(bIn[i]), i == 0) == 0) begin
                 mPhase[i] <= 2;
                 mY[i]     <= 16'd0;
               end else begin
                 mPhase[i] <= 1;
               end
             end
          1: begin
               mLeft[i] <= mLeft[i] - 1;
               if (mLeft[i] == 1) begin
                 mPhase[i] <= 2;
                 mY[i]     <= mPend[i];
               end
             end
          default: if (outReady[i]) mPhase[i] <= 0;
        endcase
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cyc dut%0d in_ready", i),  {15'd0, inReadyW[i]},  {15'd0, mPhase[i] == 0});
      chk($sformatf("cyc dut%0d out_valid", i), {15'd0, outValidW[i]}, {15'd0, mPhase[i] == 2});
      chk($sformatf("cyc dut%0d busy", i),      {15'd0, busyW[i]},     {15'd0, mPhase[i] != 0});
      chk($sformatf("cyc dut%0d y", i),         yW[i],                 mY[i]);
    end
  end

  // One full transaction with out_ready held high; checks result and latency k.
  task automatic doTx(input int idx, input logic [7:0] av, input logic [7:0] bv, input logic ae,
                      input logic [15:0] expY, input int expLat, input string nm);
    int cyc;
    chk({nm, " in_ready before"}, {15'd0, inReadyW[idx]}, 16'd1);
    aIn[idx] = av; bIn[idx] = bv; aeIn[idx] = ae;
    inValid[idx] = 1'b1; outReady[idx] = 1'b1;
    @(posedge clk); #1;
    inValid[idx] = 1'b0;
    aIn[idx] = 8'h00; bIn[idx] = 8'h00;
    cyc = 0;
    while (!outValidW[idx] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, cyc[15:0], expLat[15:0]);
    chk({nm, " y"}, yW[idx], expY);
    @(posedge clk); #1;
    chk({nm, " in_ready after"}, {15'd0, inReadyW[idx]}, 16'd1);
    chk({nm, " out_valid after"}, {15'd0, outValidW[idx]}, 16'd0);
  endtask

  initial begin
    int cyc;
    rstN = 1'b1;
    inValid = 2'b00; outReady = 2'b00; aeIn = 2'b00;
    for (int i = 0; i < 2; i++) begin aIn[i] = 8'h00; bIn[i] = 8'h00; end
    #2 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {15'd0, inReadyW[0]}, 16'd1);
    chk("reset out_valid", {15'd0, outValidW[0]}, 16'd0);
    chk("reset y", yW[0], 16'h0000);
    chk("reset busy", {15'd0, busyW[0]}, 16'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    doTx(1, 8'hFF, 8'hFF, 1'b1, 16'hFE01, 4, "noskip ffxff");
    doTx(0, 8'h01, 8'h01, 1'b1, 16'h0000, 1, "apx 01x01");
    doTx(0, 8'h03, 8'h02, 1'b1, 16'h0006, 1, "apx 03x02");
    doTx(0, 8'h02, 8'h02, 1'b1, 16'h0004, 1, "apx 02x02");
    doTx(0, 8'h01, 8'h01, 1'b0, 16'h0001, 1, "exact 01x01");
    doTx(0, 8'hAB, 8'hCD, 1'b0, 16'h88EF, 4, "exact abxcd");
    doTx(0, 8'h0F, 8'h0F, 1'b1, 16'h00E1, 1, "skip 0fx0f");
    doTx(0, 8'h00, 8'h5A, 1'b1, 16'h0000, 0, "skip 00x5a");
    doTx(0, 8'hF0, 8'h0F, 1'b1, 16'h0E10, 1, "skip f0x0f");
    doTx(0, 8'hFF, 8'hFF, 1'b1, 16'hFE01, 4, "skip ffxff");
    doTx(1, 8'h01, 8'h01, 1'b1, 16'h0000, 4, "noskip 01x01");
    doTx(1, 8'hAB, 8'hCD, 1'b0, 16'h88EF, 4, "noskip abxcd");

    // Backpressure: result held while new operands are offered and ignored.
    aIn[0] = 8'hAB; bIn[0] = 8'hCD; aeIn[0] = 1'b0;
    inValid[0] = 1'b1; outReady[0] = 1'b0;
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    cyc = 0;
    while (!outValidW[0] && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("bp latency", cyc[15:0], 16'd4);
    for (int n = 0; n < 10; n++) begin
      aIn[0] = 8'(n * 17 + 3); bIn[0] = 8'(n * 29 + 5); aeIn[0] = n[0];
      inValid[0] = n[0];
      @(posedge clk); #1;
      chk("bp y hold", yW[0], 16'h88EF);
      chk("bp in_ready", {15'd0, inReadyW[0]}, 16'd0);
      chk("bp out_valid", {15'd0, outValidW[0]}, 16'd1);
    end
    inValid[0] = 1'b0; outReady[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", {15'd0, inReadyW[0]}, 16'd1);
    chk("bp release out_valid", {15'd0, outValidW[0]}, 16'd0);
    doTx(0, 8'h03, 8'h02, 1'b1, 16'h0006, 1, "post bp 03x02");

    // Reset in the middle of a computation on the non-skipping instance.
    aIn[1] = 8'hFF; bIn[1] = 8'hFF; aeIn[1] = 1'b1;
    inValid[1] = 1'b1; outReady[1] = 1'b1;
    @(posedge clk); #1;
    inValid[1] = 1'b0;
    @(posedge clk); #3;
    rstN = 1'b0;
    #1;
    chk("midcalc rst out_valid", {15'd0, outValidW[1]}, 16'd0);
    chk("midcalc rst y", yW[1], 16'h0000);
    chk("midcalc rst in_ready", {15'd0, inReadyW[1]}, 16'd1);
    chk("midcalc rst busy", {15'd0, busyW[1]}, 16'd0);
    chk("midcalc rst y other", yW[0], 16'h0000);
    @(posedge clk); #1;
    rstN = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      chk("post rst no result", {15'd0, outValidW[1]}, 16'd0);
    end
    doTx(1, 8'h03, 8'h02, 1'b1, 16'h0006, 4, "post rst 03x02");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
